alu_host: RTL and testbench

- Requester-side sequencer for the `alu` datapath. It drives the ALU's `in`, `op_codes` and `valid` inputs and collects results from `o` and `ready`.
- Upstream logic hands it one complete operation per valid/ready handshake: opcode plus two operands.
- It serialises the operands onto the shared ALU input bus, waits for completion, captures one or two result words, and returns them on a valid/ready result port.
- It sits between the control/test logic and the `alu` instance; the ALU itself is unchanged.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_host.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_host.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the alu_host requester and its ALU-facing neighbours.
//   alu_op_t          : 2-bit ALU opcode (add / sub / mul / div)
//   alu_host_state_t  : sequencer state encoding
//   is_two_word()     : true for operations that return an A and a Q word
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10,
        DIV = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        LOAD_X = 3'd2,
        LOAD_Y = 3'd3,
        WAIT   = 3'd4,
        CAP_A  = 3'd5,
        CAP_Q  = 3'd6,
        RESP   = 3'd7
    } alu_host_state_t;

    // mul and div deliver a second (Q) word one cycle after the A word
    function automatic logic is_two_word(input alu_op_t op);
        return (op == MUL) || (op == DIV);
    endfunction

endpackage

// File: rtl/alu_host.sv
// ---------------------------------------------------------------------------
// alu_host
// Requester-side sequencer for the alu datapath. Accepts one operation per
// request handshake, serialises x then y onto the shared ALU input bus,
// waits (bounded) for ALU completion, captures one or two result words and
// presents them on a valid/ready response port.
//
// Ports
//   clk, rst                  : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake
//   req_op, req_x, req_y      : opcode and operands
//   alu_in, alu_op, alu_valid : drive to the ALU
//   alu_o, alu_ready          : result word and completion from the ALU
//   rsp_valid/rsp_ready       : response handshake
//   rsp_hi, rsp_lo, rsp_err   : A word, Q word (0 for add/sub), timeout flag
// ---------------------------------------------------------------------------
module alu_host
    import alu_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned LOAD_CYC = 2,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [W-1:0] req_x,
    input  logic [W-1:0] req_y,
    output logic [W-1:0] alu_in,
    output logic [1:0]   alu_op,
    output logic         alu_valid,
    input  logic [W-1:0] alu_o,
    input  logic         alu_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_hi,
    output logic [W-1:0] rsp_lo,
    output logic         rsp_err
);

    localparam int unsigned MAX_CNT = (LOAD_CYC > TIMEOUT) ? LOAD_CYC : TIMEOUT;
    localparam int unsigned CW      = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYC - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [W-1:0]  WORD_ZERO = {W{1'b0}};

    alu_host_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    alu_op_t         op_q, op_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            err_q, err_d;

    // State, counter, latched request and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            op_q    <= ADD;
            x_q     <= WORD_ZERO;
            y_q     <= WORD_ZERO;
            hi_q    <= WORD_ZERO;
            lo_q    <= WORD_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    // Next-state, counter and datapath-capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
                if (req_valid) begin
                    state_d = START;
                    op_d    = alu_op_t'(req_op);
                    x_d     = req_x;
                    y_d     = req_y;
                end else begin
                    state_d = IDLE;
                end
            end

            START: begin
                cnt_d   = CNT_ZERO;
                state_d = LOAD_X;
            end

            LOAD_X: begin
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = LOAD_Y;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = LOAD_X;
                end
            end

            LOAD_Y: begin
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = WAIT;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = LOAD_Y;
                end
            end

            // The A word is taken on the completion edge itself, so no
            // separate A-capture cycle is ever entered.
            WAIT: begin
                if (alu_ready) begin
                    cnt_d = CNT_ZERO;
                    hi_d  = alu_o;
                    lo_d  = WORD_ZERO;
                    err_d = 1'b0;
                    if (is_two_word(op_q)) begin
                        state_d = CAP_Q;
                    end else begin
                        state_d = RESP;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    hi_d    = WORD_ZERO;
                    lo_d    = WORD_ZERO;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = WAIT;
                end
            end

            // ALU presents Q exactly one cycle after A
            CAP_Q: begin
                lo_d    = alu_o;
                state_d = RESP;
            end

            // Results are cleared on hand-off so no stale word is left on
            // the response bus while idle.
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    hi_d    = WORD_ZERO;
                    lo_d    = WORD_ZERO;
                    err_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end

            // CAP_A and any corrupted encoding fall back to a clean idle
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                hi_d    = WORD_ZERO;
                lo_d    = WORD_ZERO;
                err_d   = 1'b0;
            end
        endcase
    end

    // Output decode from the registered state and result registers
    always_comb begin
        req_ready = 1'b0;
        alu_valid = 1'b0;
        alu_in    = WORD_ZERO;
        alu_op    = 2'b00;
        rsp_valid = 1'b0;
        rsp_hi    = hi_q;
        rsp_lo    = lo_q;
        rsp_err   = err_q;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            START: begin
                alu_valid = 1'b1;
                alu_in    = x_q;
                alu_op    = op_q;
            end
            LOAD_X: begin
                alu_in = x_q;
                alu_op = op_q;
            end
            LOAD_Y: begin
                alu_in = y_q;
                alu_op = op_q;
            end
            WAIT: begin
                alu_op = op_q;
            end
            CAP_Q: begin
                alu_op = op_q;
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_host.sv
// ---------------------------------------------------------------------------
// tb_alu_host
// Directed bench for alu_host. A behavioural ALU (plain signed arithmetic)
// answers each transaction after a chosen number of WAIT cycles; a model
// tracks each transaction by its cycle offset from the request handshake and
// a negedge compare process checks every DUT output against it.
// ---------------------------------------------------------------------------
module tb_alu_host;

    localparam int LC = 2;
    localparam int TO = 64;
    localparam int W0 = 2 * LC + 1;   // offset of the first WAIT cycle

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_x = 8'h00;
    logic [7:0] req_y = 8'h00;
    logic [7:0] alu_in;
    logic [1:0] alu_op;
    logic       alu_valid;
    logic [7:0] alu_o = 8'h5A;
    logic       alu_ready = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_hi;
    logic [7:0] rsp_lo;
    logic       rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    // stimulus configuration
    int cfg_t   = 0;     // WAIT cycles until ready (0 = never)
    int spur_k  = -1;    // offset of a spurious alu_ready pulse
    bit keep_req = 1'b0;
    logic [1:0] k_op;
    logic [7:0] k_x, k_y;

    // model of the transaction in flight
    bit         m_busy = 1'b0;
    int         m_k = 0;
    int         m_t = 0;
    int         m_krsp = 0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_x = 8'h00;
    logic [7:0] m_y = 8'h00;
    logic [15:0] m_ref = 16'h0000;

    alu_host #(.W(8), .LOAD_CYC(LC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_x(req_x), .req_y(req_y),
        .alu_in(alu_in), .alu_op(alu_op), .alu_valid(alu_valid),
        .alu_o(alu_o), .alu_ready(alu_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Reference ALU: {A, Q}. add/sub -> {result, 0}; mul -> signed 16-bit
    // product {hi, lo}; div -> {remainder, quotient}.
    function automatic logic [15:0] alu_ref(input logic [1:0] op,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
        int xi, yi, p, q, r;
        xi = $signed(x);
        yi = $signed(y);
        case (op)
            2'b00: begin p = xi + yi; return {p[7:0], 8'h00}; end
            2'b01: begin p = xi - yi; return {p[7:0], 8'h00}; end
            2'b10: begin p = xi * yi; return p[15:0]; end
            default: begin
                if (yi == 0) return {x, 8'hFF};
                q = xi / yi;
                r = xi % yi;
                return {r[7:0], q[7:0]};
            end
        endcase
    endfunction

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: offset counter from the request handshake
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_k    <= 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_op   <= req_op;
                m_x    <= req_x;
                m_y    <= req_y;
                m_t    <= cfg_t;
                m_ref  <= alu_ref(req_op, req_x, req_y);
                m_krsp <= (cfg_t == 0) ? W0 + TO : W0 + cfg_t + (req_op[1] ? 1 : 0);
            end
        end else if (m_k >= m_krsp && rsp_ready) begin
            m_busy <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // Compare process: every cycle, all DUT outputs against the model
    always @(negedge clk) begin
        logic [10:0] exp_ctrl;
        logic [16:0] exp_rsp;
        logic [7:0]  exp_in;
        bit          exp_rv;
        exp_in = 8'h00;
        if (m_busy && m_k <= LC) exp_in = m_x;
        else if (m_busy && m_k <= 2 * LC) exp_in = m_y;
        exp_rv   = m_busy && (m_k >= m_krsp);
        exp_ctrl = {!m_busy, m_busy && (m_k == 0), exp_rv, exp_in};
        check("ctrl", {req_ready, alu_valid, rsp_valid, alu_in} === exp_ctrl,
              {21'd0, req_ready, alu_valid, rsp_valid, alu_in}, {21'd0, exp_ctrl});
        if (m_busy && m_k < m_krsp)
            check("alu_op", alu_op === m_op, {30'd0, alu_op}, {30'd0, m_op});
        if (exp_rv) begin
            exp_rsp = (m_t == 0) ? 17'h00001 :
                      {m_ref[15:8], (m_op[1] ? m_ref[7:0] : 8'h00), 1'b0};
            check("rsp", {rsp_hi, rsp_lo, rsp_err} === exp_rsp,
                  {15'd0, rsp_hi, rsp_lo, rsp_err}, {15'd0, exp_rsp});
        end
    end

    // One cycle: wait for the edge, then drive the ALU responder
    task automatic tick();
        @(posedge clk);
        #1;
        alu_ready = 1'b0;
        alu_o     = 8'h5A;
        if (m_busy) begin
            if (m_t != 0 && m_k == W0 + m_t - 1) begin
                alu_ready = 1'b1;
                alu_o     = m_ref[15:8];
            end else if (m_t != 0 && m_op[1] && m_k == W0 + m_t) begin
                alu_o = m_ref[7:0];
            end else if (m_k == spur_k) begin
                alu_ready = 1'b1;
                alu_o     = 8'hEE;
            end
        end
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                           input int t, input int bp, input logic [7:0] ehi,
                           input logic [7:0] elo, input logic eerr, input int elat);
        int n;
        int lat;
        cfg_t     = t;
        req_op    = op;
        req_x     = x;
        req_y     = y;
        req_valid = 1'b1;
        rsp_ready = (bp == 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(m_busy && m_k == 0) && n < 50);
        check("handshake", m_busy && m_k == 0, n, 0);
        req_valid = keep_req;
        if (keep_req) begin
            req_op = k_op;
            req_x  = k_x;
            req_y  = k_y;
        end
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
        check("latency", lat == elat, lat, elat);
        check("rsp_lit", {rsp_hi, rsp_lo, rsp_err} === {ehi, elo, eerr},
              {15'd0, rsp_hi, rsp_lo, rsp_err}, {15'd0, ehi, elo, eerr});
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_hold", {rsp_valid, req_ready, rsp_hi, rsp_lo, rsp_err} === {2'b10, ehi, elo, eerr},
                  {13'd0, rsp_valid, req_ready, rsp_hi, rsp_lo, rsp_err},
                  {13'd0, 2'b10, ehi, elo, eerr});
        end
        rsp_ready = 1'b1;
        n = 0;
        while (m_busy && n < 10) begin
            tick();
            n++;
        end
        check("rsp_done", !m_busy, n, 0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        check("reset", {req_ready, alu_valid, alu_op, alu_in, rsp_valid, rsp_hi, rsp_lo, rsp_err} === {1'b1, 29'd0},
              {2'd0, req_ready, alu_valid, alu_op, alu_in, rsp_valid, rsp_hi, rsp_lo, rsp_err}, {2'd0, 1'b1, 29'd0});
        rst = 1'b1;
        tick();

        run_txn(2'b00, 8'h25, 8'h17, 3, 0, 8'h3C, 8'h00, 1'b0, 9);     // add
        run_txn(2'b10, 8'hFD, 8'h07, 2, 0, 8'hFF, 8'hEB, 1'b0, 9);     // mul -3*7
        run_txn(2'b01, 8'h10, 8'h20, 1, 0, 8'hF0, 8'h00, 1'b0, 7);     // sub
        keep_req = 1'b1;
        k_op = 2'b00; k_x = 8'h05; k_y = 8'h06;
        run_txn(2'b11, 8'h64, 8'h07, 4, 5, 8'h02, 8'h0E, 1'b0, 11);    // div + backpressure
        keep_req = 1'b0;
        run_txn(2'b00, 8'h05, 8'h06, 1, 0, 8'h0B, 8'h00, 1'b0, 7);     // request held while busy
        run_txn(2'b00, 8'h11, 8'h22, 0, 0, 8'h00, 8'h00, 1'b1, 70);    // timeout
        run_txn(2'b10, 8'h02, 8'h03, 5, 0, 8'h00, 8'h06, 1'b0, 12);    // normal after timeout
        run_txn(2'b00, 8'h40, 8'h01, TO, 0, 8'h41, 8'h00, 1'b0, 70);   // ready on last WAIT cycle
        spur_k = 1;
        run_txn(2'b00, 8'h01, 8'h02, 2, 0, 8'h03, 8'h00, 1'b0, 8);     // spurious ready in LOAD_X
        spur_k = -1;

        // reset in the middle of LOAD_Y
        cfg_t     = 3;
        req_op    = 2'b00;
        req_x     = 8'h33;
        req_y     = 8'h44;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !(m_busy && m_k == LC + 1); i++) tick();
        check("in_load_y", alu_in === 8'h44, {24'd0, alu_in}, 32'h44);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", {req_ready, alu_valid, alu_op, alu_in, rsp_valid, rsp_hi, rsp_lo, rsp_err} === {1'b1, 29'd0},
              {2'd0, req_ready, alu_valid, alu_op, alu_in, rsp_valid, rsp_hi, rsp_lo, rsp_err}, {2'd0, 1'b1, 29'd0});
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("no_rsp_after_rst", rsp_valid === 1'b0, {31'd0, rsp_valid}, 32'd0);
        end
        run_txn(2'b01, 8'h05, 8'h07, 2, 0, 8'hFE, 8'h00, 1'b0, 8);     // recovers cleanly

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
